dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 28 ++
 rtl/mmio_timer.sv | 74 +++++++
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder and its MMIO timer.
// The MMIO region is selected by one address bit and decoded by a 4-bit word offset.
package dmem_pkg;

    localparam int MMIO_SEL_BIT = 31;
    localparam int OFFSET_WIDTH = 4;

    localparam logic [OFFSET_WIDTH-1:0] OFF_CYCLE  = 4'd0;
    localparam logic [OFFSET_WIDTH-1:0] OFF_LED    = 4'd1;
    localparam logic [OFFSET_WIDTH-1:0] OFF_CMP    = 4'd2;
    localparam logic [OFFSET_WIDTH-1:0] OFF_CTRL   = 4'd3;
    localparam logic [OFFSET_WIDTH-1:0] OFF_STATUS = 4'd4;
    localparam logic [OFFSET_WIDTH-1:0] OFF_HALT   = 4'd5;

    typedef enum logic {
        REGION_RAM  = 1'b0,
        REGION_MMIO = 1'b1
    } region_e;

    function automatic region_e addr_region(input logic [31:0] addr);
        return addr[MMIO_SEL_BIT] ? REGION_MMIO : REGION_RAM;
    endfunction

    function automatic logic [OFFSET_WIDTH-1:0] addr_offset(input logic [31:0] addr);
        return addr[OFFSET_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running cycle counter plus compare timer with a sticky, write-1-to-clear match flag.
// Reads are read-first; the counter read returns its pre-increment value.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [31:0]             wdata,
    output logic [31:0]             rd_data,
    output logic                    irq_timer
);

    logic [31:0] cycle_q;
    logic [31:0] cmp_q;
    logic        ctrl_en_q;
    logic        status_q;

    logic match;
    logic clear;

    assign match = ctrl_en_q && (cycle_q == cmp_q);
    assign clear = wr_en && (offset == OFF_STATUS) && wdata[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (wr_en && (offset == OFF_CYCLE)) begin
            cycle_q <= wdata;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_q     <= '0;
            ctrl_en_q <= 1'b0;
        end else if (wr_en) begin
            if (offset == OFF_CMP) begin
                cmp_q <= wdata;
            end
            if (offset == OFF_CTRL) begin
                ctrl_en_q <= wdata[0];
            end
        end
    end

    // A match in the same cycle as a W1C clear must leave the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= 1'b0;
        end else if (match) begin
            status_q <= 1'b1;
        end else if (clear) begin
            status_q <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_CYCLE:  rd_data = cycle_q;
            OFF_CMP:    rd_data = cmp_q;
            OFF_CTRL:   rd_data[0] = ctrl_en_q;
            OFF_STATUS: rd_data[0] = status_q;
            default:    rd_data = '0;
        endcase
    end

    assign irq_timer = status_q & ctrl_en_q;

endmodule

// File: rtl/dmem_responder.sv
// Processor dmem-port responder: word RAM plus MMIO (timer, LEDs, halt latch).
// No handshake: every cycle is a transaction, wren=0 is a read, and q_dmem is registered.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 irq_timer,
    output logic                 halted
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           ram [0:RAM_DEPTH-1];
    logic [ADDR_WIDTH-1:0] ram_index;
    logic [OFFSET_WIDTH-1:0] offset;
    region_e               region;

    logic                 write_ok;
    logic                 ram_wr;
    logic                 mmio_wr;
    logic [31:0]          ram_rd_data;
    logic [31:0]          mmio_rd_data;
    logic [31:0]          timer_rd_data;
    logic [31:0]          q_next;
    logic [LED_WIDTH-1:0] leds_q;
    logic                 halted_q;

    // Bits [30:ADDR_WIDTH] are intentionally ignored so RAM addresses alias.
    logic unused_addr;
    assign unused_addr = ^address_dmem[30:ADDR_WIDTH];

    assign region    = addr_region(address_dmem);
    assign offset    = addr_offset(address_dmem);
    assign ram_index = address_dmem[ADDR_WIDTH-1:0];

    assign write_ok = wren && !halted_q && !reset;
    assign ram_wr   = write_ok && (region == REGION_RAM);
    assign mmio_wr  = write_ok && (region == REGION_MMIO);

    always_ff @(posedge clock) begin
        if (ram_wr) begin
            ram[ram_index] <= data;
        end
    end

    mmio_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (mmio_wr),
        .offset    (offset),
        .wdata     (data),
        .rd_data   (timer_rd_data),
        .irq_timer (irq_timer)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            leds_q <= '0;
        end else if (mmio_wr && (offset == OFF_LED)) begin
            leds_q <= data[LED_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (mmio_wr && (offset == OFF_HALT)) begin
            halted_q <= 1'b1;
        end
    end

    // RAM is write-first on a same-address store; MMIO is read-first.
    assign ram_rd_data = ram_wr ? data : ram[ram_index];

    always_comb begin
        mmio_rd_data = '0;
        case (offset)
            OFF_LED:  mmio_rd_data[LED_WIDTH-1:0] = leds_q;
            OFF_HALT: mmio_rd_data = '0;
            default:  mmio_rd_data = timer_rd_data;
        endcase
    end

    assign q_next = (region == REGION_MMIO) ? mmio_rd_data : ram_rd_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= q_next;
        end
    end

    assign leds   = leds_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, aliasing, counter wrap, timer match/W1C, LEDs, halt, reset.
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] leds;
    logic        irq_timer;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_LED    = 32'h8000_0001;
    localparam logic [31:0] A_CMP    = 32'h8000_0002;
    localparam logic [31:0] A_CTRL   = 32'h8000_0003;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_HALT   = 32'h8000_0005;

    dmem_responder #(.ADDR_WIDTH(12), .LED_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .leds         (leds),
        .irq_timer    (irq_timer),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [31:0] addr, input logic [31:0] d, input logic we);
        address_dmem = addr;
        data         = d;
        wren         = we;
    endtask

    // One rising edge; outputs are then sampled 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset with a concurrent LED store: reset must win.
        reset = 1'b1;
        drive(A_LED, 32'h0000_FFFF, 1'b1);
        cycle();
        cycle();
        check("rst_q", q_dmem, 32'h0);
        check("rst_leds", leds, 32'h0);
        check("rst_irq", irq_timer, 32'h0);
        check("rst_halted", halted, 32'h0);

        // First edge after reset deasserts reads CYCLE=0, next reads 1.
        reset = 1'b0;
        drive(A_CYCLE, 32'h0, 1'b0);
        cycle();
        check("cycle_first", q_dmem, 32'h0);
        cycle();
        check("cycle_second", q_dmem, 32'h1);

        // RAM store then load, plus alias.
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        cycle();
        drive(32'h0000_0010, 32'h0, 1'b0);
        cycle();
        check("ram_load", q_dmem, 32'hDEAD_BEEF);
        drive(32'h0000_1010, 32'h0, 1'b0);
        cycle();
        check("ram_alias", q_dmem, 32'hDEAD_BEEF);

        // Read-during-write is write-first.
        drive(32'h0000_0020, 32'h0000_0005, 1'b1);
        cycle();
        check("rdw_first", q_dmem, 32'h0000_0005);
        drive(32'h0000_0020, 32'h0, 1'b0);
        cycle();
        check("rdw_load", q_dmem, 32'h0000_0005);

        // LED register truncates, reads back zero-extended.
        drive(A_LED, 32'hFFFF_1234, 1'b1);
        cycle();
        check("led_out", leds, 32'h0000_1234);
        drive(A_LED, 32'h0, 1'b0);
        cycle();
        check("led_read", q_dmem, 32'h0000_1234);

        // Counter load and wrap (reads are pre-increment).
        drive(A_CYCLE, 32'hFFFF_FFFE, 1'b1);
        cycle();
        drive(A_CYCLE, 32'h0, 1'b0);
        cycle();
        check("wrap_fe", q_dmem, 32'hFFFF_FFFE);
        cycle();
        check("wrap_ff", q_dmem, 32'hFFFF_FFFF);
        cycle();
        check("wrap_0", q_dmem, 32'h0000_0000);
        cycle();
        check("wrap_1", q_dmem, 32'h0000_0001);

        // Timer: CMP=10, enable, restart counter at 0.
        drive(A_CMP, 32'd10, 1'b1);
        cycle();
        drive(A_CTRL, 32'h1, 1'b1);
        cycle();
        drive(A_CYCLE, 32'h0, 1'b1);
        cycle();
        drive(A_STATUS, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle();
        end
        check("irq_before_match", irq_timer, 32'h0);
        check("status_before_match", q_dmem, 32'h0);
        cycle();
        check("irq_at_match", irq_timer, 32'h1);
        cycle();
        check("status_read", q_dmem, 32'h1);

        // Reload counter so a match coincides with a W1C: set wins.
        drive(A_CYCLE, 32'd10, 1'b1);
        cycle();
        drive(A_STATUS, 32'h1, 1'b1);
        cycle();
        check("w1c_collision", irq_timer, 32'h1);
        cycle();
        check("w1c_clear", irq_timer, 32'h0);
        drive(A_STATUS, 32'h0, 1'b0);
        cycle();
        check("status_cleared", q_dmem, 32'h0);

        // Halt: later stores are ignored, reads continue.
        drive(A_HALT, 32'h1, 1'b1);
        cycle();
        check("halted_set", halted, 32'h1);
        drive(32'h0000_0010, 32'h0BAD_F00D, 1'b1);
        cycle();
        check("halt_rdw_old", q_dmem, 32'hDEAD_BEEF);
        drive(32'h0000_0010, 32'h0, 1'b0);
        cycle();
        check("halt_ram_kept", q_dmem, 32'hDEAD_BEEF);
        drive(A_LED, 32'h0000_5555, 1'b1);
        cycle();
        check("halt_led_kept", leds, 32'h0000_1234);
        drive(A_HALT, 32'h0, 1'b0);
        cycle();
        check("halt_read_zero", q_dmem, 32'h0);

        // One-cycle reset clears everything.
        reset = 1'b1;
        drive(32'h0000_0010, 32'h0, 1'b0);
        cycle();
        check("rst2_q", q_dmem, 32'h0);
        check("rst2_leds", leds, 32'h0);
        check("rst2_irq", irq_timer, 32'h0);
        check("rst2_halted", halted, 32'h0);
        reset = 1'b0;
        cycle();
        check("post_reset_ram", q_dmem, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
